// File: rtl/seg7_scan_mux.sv
// Six-digit 7-segment scan multiplexer with per-slot blanking and
// a once-per-frame snapshot of all digit patterns for tear-free display.
module seg7_scan_mux #(
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [6:0] right_seconds_in,
    input  logic [6:0] left_seconds_in,
    input  logic [6:0] right_minutes_in,
    input  logic [6:0] left_minutes_in,
    input  logic [6:0] right_hours_in,
    input  logic [6:0] left_hours_in,
    output logic [6:0] seg_out,
    output logic [5:0] an_out,
    output logic       frame_tick
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] c_q, c_d;
    logic [2:0]    d_q, d_d;
    logic [6:0]    snap_q [6];
    logic [6:0]    snap_d [6];
    logic [6:0]    ins    [6];
    logic [6:0]    seg_q, seg_d;
    logic [5:0]    an_q, an_d;
    logic          tick_q, tick_d;
    logic          frame_start;
    logic          in_blank;

    // Advance the slot/digit position, capture the frame snapshot and
    // decode the next registered outputs from the current position.
    always_comb begin
        ins[0] = right_seconds_in;
        ins[1] = left_seconds_in;
        ins[2] = right_minutes_in;
        ins[3] = left_minutes_in;
        ins[4] = right_hours_in;
        ins[5] = left_hours_in;
        c_d    = c_q;
        d_d    = d_q;
        snap_d = snap_q;
        an_d   = 6'b111111;
        seg_d  = 7'h7F;
        tick_d = 1'b0;
        frame_start = (d_q == 3'd0) && (c_q == '0);
        in_blank    = int'(c_q) < BLANK_CYCLES;
        if (enable) begin
            if (c_q == C_LAST) begin
                c_d = '0;
                d_d = (d_q == 3'd5) ? 3'd0 : d_q + 3'd1;
            end else begin
                c_d = c_q + CW'(1);
            end
            if (frame_start) begin
                // The fresh snapshot is visible on the very first slot,
                // which matters when there is no blank window.
                snap_d = ins;
                tick_d = 1'b1;
            end
            if (!in_blank) begin
                an_d  = ~(6'b000001 << d_q);
                seg_d = snap_d[d_q];
            end
        end else begin
            c_d = '0;
            d_d = 3'd0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            c_q    <= '0;
            d_q    <= 3'd0;
            snap_q <= '{default: 7'h7F};
            an_q   <= 6'b111111;
            seg_q  <= 7'h7F;
            tick_q <= 1'b0;
        end else begin
            c_q    <= c_d;
            d_q    <= d_d;
            snap_q <= snap_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            tick_q <= tick_d;
        end
    end

    assign seg_out    = seg_q;
    assign an_out     = an_q;
    assign frame_tick = tick_q;

endmodule

// File: doc/seg7_scan_mux.md
# seg7_scan_mux

Display scan multiplexer downstream of the real-clock top. It takes the six per-digit 7-segment patterns (seconds, minutes and hours; left and right digits) and time-multiplexes them onto one shared segment bus with per-digit anode enables. A blanking guard between digits prevents ghosting. All six inputs are snapshotted once per frame, so a rollover during a scan never shows a torn time.

## Interface
Parameters:
- SCAN_DIV, 100000: clock cycles per digit slot (100 MHz gives 1 ms per digit and a 6 ms frame); legal range ≥ 2.
- BLANK_CYCLES, 1000: cycles at the start of each slot with all anodes off; legal range 0 to SCAN_DIV-1.

Ports:
- clk  input  1  system clock, 100 MHz.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  scan enable; low blanks the display and holds the counters at zero.
- right_seconds_in  input  7  segment pattern, digit 0.
- left_seconds_in  input  7  segment pattern, digit 1.
- right_minutes_in  input  7  segment pattern, digit 2.
- left_minutes_in  input  7  segment pattern, digit 3.
- right_hours_in  input  7  segment pattern, digit 4.
- left_hours_in  input  7  segment pattern, digit 5.
- seg_out  output  7  shared segment bus, active-low, passed through unmodified from the snapshot.
- an_out  output  6  digit anodes, active-low; bit d selects digit d.
- frame_tick  output  1  one-cycle pulse at the start of each frame.

## Operation
- State:
  - slot counter c, range 0..SCAN_DIV-1.
  - digit index d, range 0..5.
  - six 7-bit snapshot registers snap[0..5].
  - registered outputs.
- Counting: c increments every enabled cycle. At c = SCAN_DIV-1, c wraps to 0 and d increments. At d = 5 with c wrapping, d wraps to 0.
- Snapshot: at any enabled edge where (d,c) = (0,0), all six inputs load into snap[0..5] in digit order.
- Output decode from the current (d,c), registered:
  - c < BLANK_CYCLES: an_out = 6'b111111, seg_out = 7'h7F.
  - Otherwise: an_out = ~(6'b1 << d), seg_out = snap[d].
- frame_tick = 1 on the output cycle decoded from (0,0); 0 otherwise.
- enable = 0:
  - next edge: c = 0, d = 0, an_out = 6'b111111, seg_out = 7'h7F, frame_tick = 0; snap holds.
  - on re-enable, the first enabled edge is (0,0): a fresh snapshot and a frame_tick.
- At most one anode is ever low. Blank cycles and disabled cycles have all anodes high.

## Timing
- Reset (synchronous, priority over enable):
  - next edge: c = 0, d = 0, snap[*] = 7'h7F, an_out = 6'b111111, seg_out = 7'h7F, frame_tick = 0.
- Cycle numbering: edge k is the k-th rising edge with reset low and enable high (k = 0 first).
  - At edge k, the decoded state is (d,c) with k mod (6*SCAN_DIV) = d*SCAN_DIV + c.
  - Outputs for that state are visible after edge k+1: one cycle of latency.
- Snapshot timing: an input change sampled at edge 0 is displayed. A change arriving at or after edge 1 of a frame is not shown until the next frame, 6*SCAN_DIV edges later.
- Frame length: exactly 6*SCAN_DIV cycles; frame_tick period is equal to that.
- Slot timing: each digit is lit for SCAN_DIV - BLANK_CYCLES consecutive cycles. BLANK_CYCLES = 0 gives back-to-back digits with no gap.
- Simultaneous events:
  - reset together with enable: reset wins.
  - enable falling during a lit slot: the display blanks on the following output cycle; no partial-digit completion.

## Test plan
- Reset: hold reset 10 cycles with enable = 1 and arbitrary inputs. Required: an_out = 6'b111111, seg_out = 7'h7F and frame_tick = 0 throughout, and for one cycle after release.
- Basic scan, SCAN_DIV = 8, BLANK_CYCLES = 2, inputs 7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12 on digits 0..5:
  - each 8-cycle slot shows 2 blank cycles, then 6 cycles of an_out = 111110 / seg 7'h40, then 111101 / 7'h79, and so on up to 011111 / 7'h12.
  - frame_tick pulses every 48 cycles.
- Tear-free: change left_hours_in to 7'h02 while digit 2 is lit. Required: digit 5 still shows 7'h12 this frame and 7'h02 from the next frame onward.
- Enable drop: deassert enable mid-slot of digit 3 for 5 cycles, then reassert. Required:
  - blank on the next output cycle and for the whole disabled period;
  - on resume, frame_tick pulses and digit 0 slot starts with fresh inputs.
- Reset mid-frame during digit 4: same blank and restart as the enable drop, and snap is cleared, so a digit shows 7'h7F only if its input is 7'h7F.
- BLANK_CYCLES = 0, SCAN_DIV = 4: no all-off cycles after the first frame starts; each anode is low for exactly 4 cycles per 24-cycle frame.
